// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, MDU state encoding and the per-operand hazard rule
// for the decode-stage hazard controller.
package hazard_ctrl_pkg;

   localparam int unsigned CNT_W     = 4;
   localparam logic [3:0]  MULT_LAT  = 4'd5;
   localparam logic [3:0]  DIV_LAT   = 4'd10;
   localparam logic [1:0]  TUSE_NONE = 2'd3;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_MULT = 2'd1,
      MDU_DIV  = 2'd2
   } mdu_state_e;

   // A source operand stalls when an in-flight writer of the same register
   // cannot deliver its result before D needs it; $0 is hard-wired zero.
   function automatic logic src_hazard(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic       wr_e,
      input logic [4:0] dst_e,
      input logic [1:0] tnew_e,
      input logic       wr_m,
      input logic [4:0] dst_m,
      input logic [1:0] tnew_m
   );
      return (src != 5'd0) && (tuse != TUSE_NONE) &&
             ((wr_e && (dst_e == src) && (tnew_e > tuse)) ||
              (wr_m && (dst_m == src) && (tnew_m > tuse)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute/memory hazard signals grouped between the pipeline
// (master) and the hazard controller (slave).
interface hazard_ctrl_if;

   logic [4:0] rs_D;
   logic [4:0] rt_D;
   logic [1:0] tuse_rs_D;
   logic [1:0] tuse_rt_D;
   logic       md_op_D;
   logic [4:0] write_reg_E;
   logic [4:0] write_reg_M;
   logic       reg_write_E;
   logic       reg_write_M;
   logic [1:0] tnew_E;
   logic [1:0] tnew_M;
   logic       md_start_E;
   logic       md_div_E;
   logic       stall_F;
   logic       stall_D;
   logic       flush_E;
   logic       md_busy;
   logic       md_done;

   modport master (
      output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_op_D,
             write_reg_E, write_reg_M, reg_write_E, reg_write_M,
             tnew_E, tnew_M, md_start_E, md_div_E,
      input  stall_F, stall_D, flush_E, md_busy, md_done
   );

   modport slave (
      input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_op_D,
             write_reg_E, write_reg_M, reg_write_E, reg_write_M,
             tnew_E, tnew_M, md_start_E, md_div_E,
      output stall_F, stall_D, flush_E, md_busy, md_done
   );

endinterface

// File: rtl/hazard_ctrl_mdu_timer.sv
// Multiply/divide unit latency timer: tracks how long HI/LO stay invalid
// after a launch and pulses done when the result commits.
module mdu_timer
   import hazard_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy,
   output logic done
);

   mdu_state_e       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
   logic             r_done,  w_done_nxt;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         r_state <= MDU_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      case (r_state)
         MDU_IDLE: begin
            if (start) begin
               w_state_nxt = is_div ? MDU_DIV : MDU_MULT;
               w_cnt_nxt   = is_div ? DIV_LAT : MULT_LAT;
            end
         end
         MDU_MULT, MDU_DIV: begin
            // Saturate at zero; the last busy cycle is the one holding count 1.
            w_cnt_nxt = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
            if (r_cnt <= 4'd1) begin
               w_state_nxt = MDU_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = MDU_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign busy = (r_state != MDU_IDLE);
   assign done = r_done;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls F/D and bubbles E on unresolved
// register dependencies or on HI/LO access while the MDU is computing.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  io_hz
);

   logic w_rs_hz;
   logic w_rt_hz;
   logic w_md_hz;
   logic w_stall;
   logic w_md_busy;
   logic w_md_done;

   assign w_rs_hz = src_hazard(io_hz.rs_D, io_hz.tuse_rs_D,
                               io_hz.reg_write_E, io_hz.write_reg_E, io_hz.tnew_E,
                               io_hz.reg_write_M, io_hz.write_reg_M, io_hz.tnew_M);
   assign w_rt_hz = src_hazard(io_hz.rt_D, io_hz.tuse_rt_D,
                               io_hz.reg_write_E, io_hz.write_reg_E, io_hz.tnew_E,
                               io_hz.reg_write_M, io_hz.write_reg_M, io_hz.tnew_M);

   mdu_timer u_mdu_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (io_hz.md_start_E),
      .is_div (io_hz.md_div_E),
      .busy   (w_md_busy),
      .done   (w_md_done)
   );

   // A launch still in E counts as busy so the following HI/LO op waits.
   assign w_md_hz = io_hz.md_op_D & (io_hz.md_start_E | w_md_busy);
   assign w_stall = ~reset & (w_rs_hz | w_rt_hz | w_md_hz);

   assign io_hz.stall_F = w_stall;
   assign io_hz.stall_D = w_stall;
   assign io_hz.flush_E = w_stall;
   assign io_hz.md_busy = w_md_busy;
   assign io_hz.md_done = w_md_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios then
// randomized traffic against a timestamp-based reference model.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   hazard_ctrl_if hz ();

   hazard_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .io_hz (hz)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: one outstanding MDU op, remembered by launch cycle and latency.
   int cyc      = 0;
   bit m_valid  = 1'b0;
   int m_launch = 0;
   int m_lat    = 0;

   function automatic bit m_busy(input int c);
      return m_valid && (c >= m_launch) && (c < m_launch + m_lat);
   endfunction

   function automatic bit m_done(input int c);
      return m_valid && (c == m_launch + m_lat);
   endfunction

   function automatic bit m_src(input logic [4:0] src, input logic [1:0] tuse,
                                input logic we, input logic [4:0] de, input logic [1:0] te,
                                input logic wm, input logic [4:0] dm, input logic [1:0] tm);
      if (src == 5'd0) return 1'b0;
      return (we && de == src && int'(te) > int'(tuse)) ||
             (wm && dm == src && int'(tm) > int'(tuse));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic idle_inputs();
      hz.rs_D        = 5'd0;
      hz.rt_D        = 5'd0;
      hz.tuse_rs_D   = 2'd3;
      hz.tuse_rt_D   = 2'd3;
      hz.md_op_D     = 1'b0;
      hz.write_reg_E = 5'd0;
      hz.write_reg_M = 5'd0;
      hz.reg_write_E = 1'b0;
      hz.reg_write_M = 1'b0;
      hz.tnew_E      = 2'd0;
      hz.tnew_M      = 2'd0;
      hz.md_start_E  = 1'b0;
      hz.md_div_E    = 1'b0;
   endtask

   // One pipeline cycle: check combinational stalls, clock, check MDU flags.
   task automatic step();
      bit exp_stall;
      #2;
      exp_stall = !reset &&
                  (m_src(hz.rs_D, hz.tuse_rs_D, hz.reg_write_E, hz.write_reg_E, hz.tnew_E,
                         hz.reg_write_M, hz.write_reg_M, hz.tnew_M) ||
                   m_src(hz.rt_D, hz.tuse_rt_D, hz.reg_write_E, hz.write_reg_E, hz.tnew_E,
                         hz.reg_write_M, hz.write_reg_M, hz.tnew_M) ||
                   (hz.md_op_D && (hz.md_start_E || m_busy(cyc))));
      check("stall_F", 32'(hz.stall_F), 32'(exp_stall));
      check("stall_D", 32'(hz.stall_D), 32'(exp_stall));
      check("flush_E", 32'(hz.flush_E), 32'(exp_stall));
      if (hz.md_start_E && !reset) check("start_while_busy", 32'(hz.md_busy), 32'd0);
      @(posedge clk);
      cyc++;
      if (reset) m_valid = 1'b0;
      else if (hz.md_start_E && !m_busy(cyc - 1)) begin
         m_valid  = 1'b1;
         m_launch = cyc;
         m_lat    = hz.md_div_E ? 10 : 5;
      end
      #1;
      check("md_busy", 32'(hz.md_busy), 32'(m_busy(cyc)));
      check("md_done", 32'(hz.md_done), 32'(m_done(cyc)));
   endtask

   initial begin
      int busy_cnt;
      reset = 1'b1;
      idle_inputs();
      repeat (3) step();
      check("reset_busy", 32'(hz.md_busy), 32'd0);
      check("reset_done", 32'(hz.md_done), 32'd0);
      reset = 1'b0;

      // lw $8 in E, then in M, then result ready
      hz.reg_write_E = 1'b1; hz.write_reg_E = 5'd8; hz.tnew_E = 2'd2;
      hz.rs_D = 5'd8; hz.tuse_rs_D = 2'd0;
      #1 check("lw_in_E_stall", 32'(hz.stall_F), 32'd1);
      step();
      hz.reg_write_E = 1'b0;
      hz.reg_write_M = 1'b1; hz.write_reg_M = 5'd8; hz.tnew_M = 2'd1;
      #1 check("lw_in_M_stall", 32'(hz.stall_D), 32'd1);
      step();
      hz.tnew_M = 2'd0;
      #1 check("lw_ready_nostall", 32'(hz.flush_E), 32'd0);
      step();

      // $0 never stalls
      idle_inputs();
      hz.reg_write_E = 1'b1; hz.write_reg_E = 5'd0; hz.tnew_E = 2'd2;
      hz.rs_D = 5'd0; hz.tuse_rs_D = 2'd0;
      #1 check("r0_nostall", 32'(hz.stall_F), 32'd0);
      step();

      // mult launch, mflo waits for the whole busy window
      idle_inputs();
      hz.md_start_E = 1'b1; hz.md_div_E = 1'b0;
      step();
      hz.md_start_E = 1'b0; hz.md_op_D = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1 check("mflo_stall", 32'(hz.stall_F), 32'd1);
         step();
      end
      #1 check("mflo_release", 32'(hz.stall_F), 32'd0);
      check("mult_done", 32'(hz.md_done), 32'd1);
      // back-to-back mult launched in the done cycle
      hz.md_op_D = 1'b0; hz.md_start_E = 1'b1;
      step();
      check("b2b_busy", 32'(hz.md_busy), 32'd1);
      hz.md_start_E = 1'b0;
      repeat (6) step();

      // div busy window length
      hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
      step();
      hz.md_start_E = 1'b0; hz.md_div_E = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (hz.md_busy === 1'b1) busy_cnt++;
         step();
      end
      check("div_busy_cycles", 32'(busy_cnt), 32'd10);

      // div aborted by reset in its fourth busy cycle
      hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
      step();
      hz.md_start_E = 1'b0; hz.md_div_E = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      check("abort_busy", 32'(hz.md_busy), 32'd0);
      check("abort_done", 32'(hz.md_done), 32'd0);
      reset = 1'b0;
      repeat (12) step();

      // reset masks every stall source
      reset = 1'b1;
      hz.reg_write_E = 1'b1; hz.write_reg_E = 5'd9; hz.tnew_E = 2'd2;
      hz.rs_D = 5'd9; hz.rt_D = 5'd9; hz.tuse_rs_D = 2'd0; hz.tuse_rt_D = 2'd0;
      hz.md_op_D = 1'b1; hz.md_start_E = 1'b1;
      #1 check("reset_masks_stall", 32'(hz.stall_F), 32'd0);
      step();
      reset = 1'b0;
      idle_inputs();
      step();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         hz.rs_D        = 5'($urandom_range(0, 3));
         hz.rt_D        = 5'($urandom_range(0, 3));
         hz.tuse_rs_D   = 2'($urandom_range(0, 3));
         hz.tuse_rt_D   = 2'($urandom_range(0, 3));
         hz.write_reg_E = 5'($urandom_range(0, 3));
         hz.write_reg_M = 5'($urandom_range(0, 3));
         hz.reg_write_E = 1'($urandom_range(0, 1));
         hz.reg_write_M = 1'($urandom_range(0, 1));
         hz.tnew_E      = 2'($urandom_range(0, 3));
         hz.tnew_M      = 2'($urandom_range(0, 3));
         hz.md_op_D     = ($urandom_range(0, 2) == 0);
         hz.md_div_E    = 1'($urandom_range(0, 1));
         hz.md_start_E  = !m_busy(cyc) && ($urandom_range(0, 5) == 0);
         reset          = ($urandom_range(0, 59) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 rs_D, rt_D  input  5 each  source register numbers of the instruction in D.
REQ-004 tuse_rs_D, tuse_rt_D  input  2 each  cycles until D instruction needs rs/rt; 3 = not used.
REQ-005 md_op_D  input  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-006 write_reg_E, write_reg_M  input  5 each  destination register of E/M instruction.
REQ-007 reg_write_E, reg_write_M  input  1 each  E/M instruction writes the register file.
REQ-008 tnew_E, tnew_M  input  2 each  cycles until E/M result is forwardable; 0 = available now.
REQ-009 md_start_E  input  1  mult/div instruction is in E this cycle; launches the MDU.
REQ-010 md_div_E  input  1  qualifies md_start_E: 0 = multiply, 1 = divide.
REQ-011 stall_F  output  1  hold PC.
REQ-012 stall_D  output  1  hold the F-to-D register.
REQ-013 flush_E  output  1  load a bubble (all-zero control) into the D-to-E register.
REQ-014 md_busy  output  1  MDU computing; HI/LO not valid.
REQ-015 md_done  output  1  one-cycle pulse, MDU result committed to HI/LO.

Function
REQ-016 Data hazard on rs SHALL be raised when rs_D != 0, and either (reg_write_E, write_reg_E == rs_D, tnew_E > tuse_rs_D) or (reg_write_M, write_reg_M == rs_D, tnew_M > tuse_rs_D); same rule for rt.
REQ-017 Register 0 SHALL never cause a hazard.
REQ-018 MDU hazard SHALL be raised when md_op_D and (md_start_E or md_busy).
REQ-019 stall_F, stall_D, flush_E SHALL all equal (data hazard OR MDU hazard), combinationally, same cycle.
REQ-020 MDU state machine states: IDLE, MULT, DIV.
REQ-021 IDLE -> MULT when md_start_E && !md_div_E at a clock edge; 4-bit counter loaded with 5.
REQ-022 IDLE -> DIV when md_start_E && md_div_E; counter loaded with 10.
REQ-023 In MULT/DIV the counter SHALL decrement by 1 per cycle; on reaching 0 state returns to IDLE.
REQ-024 md_busy SHALL be 1 exactly in MULT/DIV, i.e. for 5 (mult) or 10 (div) cycles after the launching edge.
REQ-025 md_done SHALL be registered, high for one cycle, the cycle after the last md_busy cycle.
REQ-026 md_start_E while md_busy SHALL be ignored (unreachable by REQ-018); bench asserts it never occurs.
REQ-027 md_start_E in the same cycle md_done is high SHALL launch normally (IDLE already reached).
REQ-028 Counter SHALL never wrap; decrement below 0 is not permitted.

Reset
REQ-029 Reset SHALL force state IDLE, counter 0, md_busy 0, md_done 0, aborting any MDU operation.
REQ-030 While reset is high stall_F, stall_D, flush_E SHALL be 0 regardless of inputs.
REQ-031 First MDU launch possible at the first edge after reset deasserts.

Structure
REQ-032 Shared package SHALL hold MULT_LAT=5, DIV_LAT=10, the MDU state enum, and TUSE_NONE=3.
REQ-033 Counter + state machine SHALL be a sub-module mdu_timer (ports clk, reset, start, is_div, busy, done); hazard comparators stay in hazard_ctrl.

Verification
REQ-034 lw $8 in E (tnew_E=2), D uses rs=8 tuse=0 -> stall_F=stall_D=flush_E=1 same cycle; with tnew_E=1 next cycle in M, tuse=0 -> still stall; tnew_M=0 -> 0.
REQ-035 write_reg_E=0, reg_write_E=1, tnew_E=2, rs_D=0 -> no stall.
REQ-036 md_start_E=1, md_div_E=0 at edge T -> md_busy high cycles T+1..T+5, md_done high cycle T+6 only; mflo in D during T+1..T+5 -> stall, released at T+6.
REQ-037 div launch -> md_busy exactly 10 cycles; reset asserted at busy cycle 4 -> md_busy=0, md_done=0 next cycle, no later md_done.
REQ-038 mult back-to-back: second md_start_E coincident with md_done -> new 5-cycle busy window begins immediately.
REQ-039 reset=1 with all hazard conditions true -> stall_F=stall_D=flush_E=0.
